// File: rtl/xaui_rx_framer_pkg.sv
// Shared definitions for the XAUI receive framer: word type codes, metadata
// field positions, state encoding and length/valid entry layout.
package xaui_rx_framer_pkg;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        PKT_S  = 2'd1,
        DROP_S = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_META = 2'b01;
    localparam logic [1:0] TYPE_MID  = 2'b11;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    localparam int META_PORT_HI    = 127;
    localparam int META_PORT_LO    = 124;
    localparam int META_LEN_HI     = 123;
    localparam int META_LEN_LO     = 113;
    localparam int META_OUTPORT_HI = 55;
    localparam int META_OUTPORT_LO = 47;
    localparam int META_TS_HI      = 31;
    localparam int META_TS_LO      = 0;

    typedef struct packed {
        logic        good;
        logic [10:0] len;
    } valid_entry_t;

    // LEN and OUTPORT are left zero; the downstream block fills them in.
    function automatic logic [133:0] build_meta(input logic [3:0] port_id, input logic [31:0] ts);
        logic [133:0] w;
        w = 134'd0;
        w[133:132] = TYPE_META;
        w[META_PORT_HI:META_PORT_LO] = port_id;
        w[META_LEN_HI:META_LEN_LO] = 11'd0;
        w[META_OUTPORT_HI:META_OUTPORT_LO] = 9'd0;
        w[META_TS_HI:META_TS_LO] = ts;
        return w;
    endfunction

    function automatic logic [133:0] build_word(input logic [1:0] typ, input logic [3:0] emp,
                                                input logic [127:0] data);
        return {typ, emp, data};
    endfunction

endpackage

// File: rtl/xaui_rx_framer_if.sv
// MAC receive stream plus packet/length FIFO write side of the framer.
interface xaui_rx_framer_if;
    logic         in_mac_valid;
    logic         in_mac_sop;
    logic         in_mac_eop;
    logic [3:0]   in_mac_empty;
    logic         in_mac_err;
    logic [127:0] in_mac_data;
    logic         out_xaui_pkt_wr;
    logic [133:0] out_xaui_pkt;
    logic         in_xaui_pkt_almostfull;
    logic         out_xaui_pkt_valid_wr;
    logic [11:0]  out_xaui_pkt_valid;

    modport slave (
        input  in_mac_valid, in_mac_sop, in_mac_eop, in_mac_empty, in_mac_err, in_mac_data,
        input  in_xaui_pkt_almostfull,
        output out_xaui_pkt_wr, out_xaui_pkt, out_xaui_pkt_valid_wr, out_xaui_pkt_valid
    );

    modport master (
        output in_mac_valid, in_mac_sop, in_mac_eop, in_mac_empty, in_mac_err, in_mac_data,
        output in_xaui_pkt_almostfull,
        input  out_xaui_pkt_wr, out_xaui_pkt, out_xaui_pkt_valid_wr, out_xaui_pkt_valid
    );
endinterface

// File: rtl/xaui_rx_framer_stat_cnt32.sv
// Wrapping 32-bit event counter used for the framer statistics.
module xaui_rx_framer_stat_cnt32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);
    // Count one event per cycle in which inc is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (inc) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/xaui_rx_framer.sv
// Converts the MAC SOP/EOP word stream into meta/middle/tail packet words
// with one length/valid entry per frame; admits or drops whole frames.
module xaui_rx_framer
    import xaui_rx_framer_pkg::*;
#(
    parameter logic [3:0] PORT_ID   = 4'd0,
    parameter int         MAX_WORDS = 96,
    parameter int         MIN_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    xaui_rx_framer_if.slave   bus,
    output logic [31:0]       out_frame_cnt,
    output logic [31:0]       out_err_cnt,
    output logic [31:0]       out_drop_cnt
);
    localparam logic [10:0] LAST_BASE = 11'((MAX_WORDS - 1) * 16);
    localparam logic [10:0] TRUNC_LEN = 11'(MAX_WORDS * 16);
    localparam logic [10:0] MIN_LEN   = 11'(MIN_BYTES);

    state_t       state_r, state_s;
    logic [127:0] s_data_r, s_data_s;
    logic [10:0]  byte_cnt_r, byte_cnt_s;
    logic         tail_pend_r, tail_pend_s;
    logic [3:0]   tail_emp_r, tail_emp_s;
    valid_entry_t tail_entry_r, tail_entry_s;
    logic [31:0]  ts_r;
    logic         pkt_wr_r, pkt_wr_s;
    logic [133:0] pkt_r, pkt_s;
    logic         vwr_r, vwr_s;
    valid_entry_t val_r, val_s;
    logic         inc_frame_s, inc_err_s, inc_drop_s;
    logic         acc_sop_s;
    logic [10:0]  len_base_s, eop_len_s;
    logic         eop_good_s;

    assign acc_sop_s  = bus.in_mac_valid & bus.in_mac_sop;
    // Bytes already held by the frame: none at SOP, the counter once inside it.
    assign len_base_s = (state_r == PKT_S) ? byte_cnt_r : 11'd0;
    assign eop_len_s  = len_base_s + 11'd16 - {7'd0, bus.in_mac_empty};
    assign eop_good_s = !bus.in_mac_err && (eop_len_s >= MIN_LEN);

    // Next-state, staging and output-word selection.
    always_comb begin
        state_s      = state_r;
        s_data_s     = s_data_r;
        byte_cnt_s   = byte_cnt_r;
        tail_pend_s  = 1'b0;
        tail_emp_s   = tail_emp_r;
        tail_entry_s = tail_entry_r;
        pkt_wr_s     = 1'b0;
        pkt_s        = pkt_r;
        vwr_s        = 1'b0;
        val_s        = val_r;
        inc_frame_s  = 1'b0;
        inc_err_s    = 1'b0;
        inc_drop_s   = 1'b0;

        if (tail_pend_r) begin
            pkt_wr_s    = 1'b1;
            pkt_s       = build_word(TYPE_TAIL, tail_emp_r, s_data_r);
            vwr_s       = 1'b1;
            val_s       = tail_entry_r;
            inc_frame_s = tail_entry_r.good;
            inc_err_s   = !tail_entry_r.good;
        end else begin
            vwr_s = 1'b0;
        end

        case (state_r)
            IDLE_S: begin
                if (acc_sop_s) begin
                    // A SOP colliding with the tail write is dropped like a full FIFO.
                    if (bus.in_xaui_pkt_almostfull || tail_pend_r) begin
                        inc_drop_s = 1'b1;
                        state_s    = bus.in_mac_eop ? IDLE_S : DROP_S;
                    end else begin
                        pkt_wr_s   = 1'b1;
                        pkt_s      = build_meta(PORT_ID, ts_r);
                        s_data_s   = bus.in_mac_data;
                        byte_cnt_s = 11'd16;
                        if (bus.in_mac_eop) begin
                            tail_pend_s       = 1'b1;
                            tail_emp_s        = bus.in_mac_empty;
                            tail_entry_s.good = eop_good_s;
                            tail_entry_s.len  = eop_len_s;
                            state_s           = IDLE_S;
                        end else begin
                            state_s = PKT_S;
                        end
                    end
                end else begin
                    state_s = IDLE_S;
                end
            end
            PKT_S: begin
                if (bus.in_mac_valid) begin
                    pkt_wr_s = 1'b1;
                    pkt_s    = build_word(TYPE_MID, 4'd0, s_data_r);
                    if (bus.in_mac_sop) begin
                        // Missing EOP: close the old frame with a dummy tail.
                        s_data_s          = 128'd0;
                        tail_pend_s       = 1'b1;
                        tail_emp_s        = 4'hF;
                        tail_entry_s.good = 1'b0;
                        tail_entry_s.len  = byte_cnt_r + 11'd1;
                        inc_drop_s        = 1'b1;
                        state_s           = bus.in_mac_eop ? IDLE_S : DROP_S;
                    end else if (bus.in_mac_eop) begin
                        s_data_s          = bus.in_mac_data;
                        tail_pend_s       = 1'b1;
                        tail_emp_s        = bus.in_mac_empty;
                        tail_entry_s.good = eop_good_s;
                        tail_entry_s.len  = eop_len_s;
                        state_s           = IDLE_S;
                    end else if (byte_cnt_r == LAST_BASE) begin
                        s_data_s          = bus.in_mac_data;
                        tail_pend_s       = 1'b1;
                        tail_emp_s        = 4'd0;
                        tail_entry_s.good = 1'b0;
                        tail_entry_s.len  = TRUNC_LEN;
                        state_s           = DROP_S;
                    end else begin
                        s_data_s   = bus.in_mac_data;
                        byte_cnt_s = byte_cnt_r + 11'd16;
                    end
                end else begin
                    state_s = PKT_S;
                end
            end
            DROP_S: begin
                if (bus.in_mac_valid && bus.in_mac_eop) begin
                    state_s = IDLE_S;
                end else begin
                    state_s = DROP_S;
                end
            end
            default: begin
                state_s = IDLE_S;
            end
        endcase
    end

    // State, staging register, timestamp and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE_S;
            s_data_r     <= 128'd0;
            byte_cnt_r   <= 11'd0;
            tail_pend_r  <= 1'b0;
            tail_emp_r   <= 4'd0;
            tail_entry_r <= '0;
            ts_r         <= 32'd0;
            pkt_wr_r     <= 1'b0;
            pkt_r        <= 134'd0;
            vwr_r        <= 1'b0;
            val_r        <= '0;
        end else begin
            state_r      <= state_s;
            s_data_r     <= s_data_s;
            byte_cnt_r   <= byte_cnt_s;
            tail_pend_r  <= tail_pend_s;
            tail_emp_r   <= tail_emp_s;
            tail_entry_r <= tail_entry_s;
            ts_r         <= ts_r + 32'd1;
            pkt_wr_r     <= pkt_wr_s;
            pkt_r        <= pkt_s;
            vwr_r        <= vwr_s;
            val_r        <= val_s;
        end
    end

    assign bus.out_xaui_pkt_wr       = pkt_wr_r;
    assign bus.out_xaui_pkt          = pkt_r;
    assign bus.out_xaui_pkt_valid_wr = vwr_r;
    assign bus.out_xaui_pkt_valid    = val_r;

    xaui_rx_framer_stat_cnt32 u_frame_cnt (.clk(clk), .reset(reset), .inc(inc_frame_s), .count(out_frame_cnt));
    xaui_rx_framer_stat_cnt32 u_err_cnt   (.clk(clk), .reset(reset), .inc(inc_err_s),   .count(out_err_cnt));
    xaui_rx_framer_stat_cnt32 u_drop_cnt  (.clk(clk), .reset(reset), .inc(inc_drop_s),  .count(out_drop_cnt));

endmodule

// File: tb/tb_xaui_rx_framer.sv
// Directed bench for xaui_rx_framer: per-cycle vector table plus sequences
// for truncation, the follow-on frame and reset mid-frame.
module tb_xaui_rx_framer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    xaui_rx_framer_if bus();
    logic [31:0] frame_cnt, err_cnt, drop_cnt;

    xaui_rx_framer #(.PORT_ID(4'd5), .MAX_WORDS(96), .MIN_BYTES(64)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .out_frame_cnt(frame_cnt), .out_err_cnt(err_cnt), .out_drop_cnt(drop_cnt)
    );

    typedef struct {
        logic       v, sop, eop;
        logic [3:0] emp;
        logic       err;
        logic [7:0] tag;
        logic       af;
        logic       wr;
        logic [1:0] typ;
        logic [3:0] xemp;
        logic [7:0] xtag;
        logic       vwr;
        logic [11:0] xval;
    } vec_t;

    vec_t vq[$];
    int passed = 0;
    int total = 0;
    logic [31:0] cyc;
    logic [31:0] sop_ts = 32'd0;
    logic [133:0] exp_pkt = 134'd0;
    logic [11:0] exp_val = 12'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic v, s, e, input logic [3:0] emp, input logic err,
                       input logic [7:0] tag, input logic af, input logic wr, input logic [1:0] typ,
                       input logic [3:0] xemp, input logic [7:0] xtag, input logic vwr,
                       input logic [11:0] xval);
        vec_t t;
        t.v = v; t.sop = s; t.eop = e; t.emp = emp; t.err = err; t.tag = tag; t.af = af;
        t.wr = wr; t.typ = typ; t.xemp = xemp; t.xtag = xtag; t.vwr = vwr; t.xval = xval;
        vq.push_back(t);
    endtask

    task automatic idle();
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 12'h000);
    endtask

    // Data word of beat i: data = {16{i}}, expected pkt type 11 carrying the previous beat.
    task automatic mid(input logic [7:0] tag, input logic [7:0] prev, input logic af);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, tag, af, 1'b1, 2'b11, 4'd0, prev, 1'b0, 12'h000);
    endtask

    task automatic meta(input logic [7:0] tag);
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, tag, 1'b0, 1'b1, 2'b01, 4'd0, 8'h00, 1'b0, 12'h000);
    endtask

    task automatic drv(input logic v, s, e, input logic [3:0] emp, input logic err,
                       input logic [7:0] tag, input logic af);
        @(negedge clk);
        bus.in_mac_valid = v;
        bus.in_mac_sop = s;
        bus.in_mac_eop = e;
        bus.in_mac_empty = emp;
        bus.in_mac_err = err;
        bus.in_mac_data = {16{tag}};
        bus.in_xaui_pkt_almostfull = af;
        if (v && s) sop_ts = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tagname);
        chk({tagname, " pkt_wr"}, {133'd0, bus.out_xaui_pkt_wr}, 134'd0);
        chk({tagname, " pkt"}, bus.out_xaui_pkt, 134'd0);
        chk({tagname, " valid_wr"}, {133'd0, bus.out_xaui_pkt_valid_wr}, 134'd0);
        chk({tagname, " valid"}, {122'd0, bus.out_xaui_pkt_valid}, 134'd0);
        chk({tagname, " frame_cnt"}, {102'd0, frame_cnt}, 134'd0);
        chk({tagname, " err_cnt"}, {102'd0, err_cnt}, 134'd0);
        chk({tagname, " drop_cnt"}, {102'd0, drop_cnt}, 134'd0);
    endtask

    initial begin
        int nd, nv, nm;
        logic [133:0] last_pkt;
        logic [11:0] last_val;

        bus.in_mac_valid = 1'b0; bus.in_mac_sop = 1'b0; bus.in_mac_eop = 1'b0;
        bus.in_mac_empty = 4'd0; bus.in_mac_err = 1'b0; bus.in_mac_data = 128'd0;
        bus.in_xaui_pkt_almostfull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // 64-byte frame, 4 words
        meta(8'h10); mid(8'h11, 8'h10, 1'b0); mid(8'h12, 8'h11, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h13, 1'b0, 1'b1, 2'b11, 4'd0, 8'h12, 1'b0, 12'h000);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 4'd0, 8'h13, 1'b1, 12'h840);
        idle();
        // 65-byte frame, 5 words, empty 15
        meta(8'h20); mid(8'h21, 8'h20, 1'b0); mid(8'h22, 8'h21, 1'b0); mid(8'h23, 8'h22, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 8'h24, 1'b0, 1'b1, 2'b11, 4'd0, 8'h23, 1'b0, 12'h000);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 4'hF, 8'h24, 1'b1, 12'h841);
        idle();
        // almost-full at SOP: whole frame dropped
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h30, 1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 12'h000);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h31, 1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 12'h000);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h32, 1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 12'h000);
        idle();
        // almost-full rising mid-frame: frame completes
        meta(8'h40); mid(8'h41, 8'h40, 1'b1); mid(8'h42, 8'h41, 1'b1);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h43, 1'b1, 1'b1, 2'b11, 4'd0, 8'h42, 1'b0, 12'h000);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 4'd0, 8'h43, 1'b1, 12'h840);
        idle();
        // 64-byte frame with err on EOP
        meta(8'h50); mid(8'h51, 8'h50, 1'b0); mid(8'h52, 8'h51, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 8'h53, 1'b0, 1'b1, 2'b11, 4'd0, 8'h52, 1'b0, 12'h000);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 4'd0, 8'h53, 1'b1, 12'h040);
        idle();
        // SOP after 2 words without EOP: dummy tail, next frame dropped
        meta(8'h60); mid(8'h61, 8'h60, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h70, 1'b0, 1'b1, 2'b11, 4'd0, 8'h61, 1'b0, 12'h000);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h71, 1'b0, 1'b1, 2'b10, 4'hF, 8'h00, 1'b1, 12'h021);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h72, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 12'h000);
        idle();
        // single-word frame, then SOP colliding with its tail write
        add(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h80, 1'b0, 1'b1, 2'b01, 4'd0, 8'h00, 1'b0, 12'h000);
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h90, 1'b0, 1'b1, 2'b10, 4'd0, 8'h80, 1'b1, 12'h010);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h91, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 12'h000);
        idle();
        // valid gaps mid-frame
        meta(8'hA0); idle(); mid(8'hA1, 8'hA0, 1'b0); idle(); mid(8'hA2, 8'hA1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'hA3, 1'b0, 1'b1, 2'b11, 4'd0, 8'hA2, 1'b0, 12'h000);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 4'd0, 8'hA3, 1'b1, 12'h840);
        idle();

        for (int i = 0; i < vq.size(); i++) begin
            drv(vq[i].v, vq[i].sop, vq[i].eop, vq[i].emp, vq[i].err, vq[i].tag, vq[i].af);
            if (vq[i].wr) begin
                if (vq[i].typ == 2'b01) begin
                    exp_pkt = 134'd0;
                    exp_pkt[133:132] = 2'b01;
                    exp_pkt[127:124] = 4'd5;
                    exp_pkt[31:0] = sop_ts;
                end else begin
                    exp_pkt = {vq[i].typ, vq[i].xemp, {16{vq[i].xtag}}};
                end
            end
            if (vq[i].vwr) exp_val = vq[i].xval;
            chk($sformatf("v%0d pkt_wr", i), {133'd0, bus.out_xaui_pkt_wr}, {133'd0, vq[i].wr});
            chk($sformatf("v%0d pkt", i), bus.out_xaui_pkt, exp_pkt);
            chk($sformatf("v%0d valid_wr", i), {133'd0, bus.out_xaui_pkt_valid_wr}, {133'd0, vq[i].vwr});
            chk($sformatf("v%0d valid", i), {122'd0, bus.out_xaui_pkt_valid}, {122'd0, exp_val});
        end
        chk("table frame_cnt", {102'd0, frame_cnt}, 134'd4);
        chk("table err_cnt", {102'd0, err_cnt}, 134'd3);
        chk("table drop_cnt", {102'd0, drop_cnt}, 134'd3);

        // 120-word frame: truncated at 96 words
        nd = 0; nv = 0; last_pkt = 134'd0; last_val = 12'd0;
        for (int i = 1; i <= 124; i++) begin
            if (i <= 120) drv(1'b1, i == 1, i == 120, 4'd0, 1'b0, i[7:0], 1'b0);
            else          drv(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
            if (bus.out_xaui_pkt_wr && bus.out_xaui_pkt[133:132] != 2'b01) begin
                nd++;
                last_pkt = bus.out_xaui_pkt;
            end
            if (bus.out_xaui_pkt_valid_wr) begin
                nv++;
                last_val = bus.out_xaui_pkt_valid;
            end
        end
        chk("trunc data writes", 134'(nd), 134'd96);
        chk("trunc tail word", last_pkt, {2'b10, 4'd0, {16{8'd96}}});
        chk("trunc valid writes", 134'(nv), 134'd1);
        chk("trunc valid", {122'd0, last_val}, {122'd0, 12'h600});
        chk("trunc err_cnt", {102'd0, err_cnt}, 134'd4);

        // next frame after truncation is accepted
        nm = 0; nv = 0; last_val = 12'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drv(1'b1, i == 0, i == 3, 4'd0, 1'b0, 8'hB0 + 8'(i), 1'b0);
            else       drv(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
            if (bus.out_xaui_pkt_wr && bus.out_xaui_pkt[133:132] == 2'b01) nm++;
            if (bus.out_xaui_pkt_valid_wr) begin
                nv++;
                last_val = bus.out_xaui_pkt_valid;
            end
        end
        chk("post-trunc meta", 134'(nm), 134'd1);
        chk("post-trunc valid", {122'd0, last_val}, {122'd0, 12'h840});
        chk("post-trunc frame_cnt", {102'd0, frame_cnt}, 134'd5);
        chk("post-trunc drop_cnt", {102'd0, drop_cnt}, 134'd3);

        // reset mid-frame: partial frame abandoned, no tail afterwards
        drv(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'hC0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'hC1, 1'b0);
        @(negedge clk);
        bus.in_mac_valid = 1'b0; bus.in_mac_sop = 1'b0; bus.in_mac_eop = 1'b0;
        reset = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
            if (bus.out_xaui_pkt_wr || bus.out_xaui_pkt_valid_wr) nd++;
        end
        chk("post-reset writes", 134'(nd), 134'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
